// File: rtl/imm_ext_pkg.sv
// Shared widths, FSM state type and requester ids for the immediate-extension arbiter.
package imm_ext_pkg;
    localparam int IMM_W  = 16;
    localparam int DATA_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam logic ID_ALU = 1'b0;
    localparam logic ID_BR  = 1'b1;
endpackage

// File: rtl/imm_ext_arbiter_if.sv
// Request/grant/result bundle between the two immediate requesters, the arbiter and its consumer.
interface imm_ext_arbiter_if;
    import imm_ext_pkg::*;

    logic              req0;
    logic              req1;
    logic [IMM_W-1:0]  imm0;
    logic [IMM_W-1:0]  imm1;
    logic              zext0;
    logic              zext1;
    logic              gnt0;
    logic              gnt1;
    logic              out_valid;
    logic              out_id;
    logic [DATA_W-1:0] out_data;
    logic              out_ack;
    logic              flush;

    modport slave (
        input  req0, req1, imm0, imm1, zext0, zext1, out_ack, flush,
        output gnt0, gnt1, out_valid, out_id, out_data
    );

    modport master (
        output req0, req1, imm0, imm1, zext0, zext1, out_ack, flush,
        input  gnt0, gnt1, out_valid, out_id, out_data
    );
endinterface

// File: rtl/imm_ext_arbiter_sign_ext.sv
// sign_ext_unit: combinational 16->32 immediate extension.
// Zero mode via zext is honoured only when IMM_ZERO_EXT_EN is defined; otherwise always sign mode.
module sign_ext_unit
    import imm_ext_pkg::*;
(
    input  logic [IMM_W-1:0]         imm,
    input  logic                     zext,
    output logic signed [DATA_W-1:0] ext
);
`ifdef IMM_ZERO_EXT_EN
    assign ext = zext ? {{(DATA_W-IMM_W){1'b0}}, imm}
                      : {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
`else
    logic unused_zext;
    assign unused_zext = zext;
    assign ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
`endif
endmodule

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter between ALU-immediate and branch-offset requesters; returns one extended
// (and, for branches, shifted) value per transaction. Zero-extend support: IMM_ZERO_EXT_EN.
module imm_ext_arbiter
    import imm_ext_pkg::*;
#(
    parameter int BR_SHIFT = 2
) (
    input logic               clk,
    input logic               rst,
    imm_ext_arbiter_if.slave  bus
);
    state_t                   state_p1, state_n;
    logic                     ptr_p1, ptr_n;
    logic                     vld_p1, vld_n;
    logic                     id_p1, id_n;
    logic signed [DATA_W-1:0] data_p1, data_n;
    logic                     gnt0_p1, gnt0_n;
    logic                     gnt1_p1, gnt1_n;

    logic                     sel_id;
    logic [IMM_W-1:0]         imm_sel;
    logic                     zext_sel;
    logic signed [DATA_W-1:0] ext_val;

    function automatic logic signed [DATA_W-1:0] br_scale(input logic signed [DATA_W-1:0] v);
        return v <<< BR_SHIFT;
    endfunction

    // The pointer only matters on a tie; a lone request always wins.
    always_comb begin
        if (bus.req0 && bus.req1)
            sel_id = ptr_p1;
        else if (bus.req1)
            sel_id = ID_BR;
        else
            sel_id = ID_ALU;
    end

    assign imm_sel  = (sel_id == ID_BR) ? bus.imm1  : bus.imm0;
    assign zext_sel = (sel_id == ID_BR) ? bus.zext1 : bus.zext0;

    sign_ext_unit u_ext (
        .imm  (imm_sel),
        .zext (zext_sel),
        .ext  (ext_val)
    );

    always_comb begin
        state_n = state_p1;
        ptr_n   = ptr_p1;
        vld_n   = vld_p1;
        id_n    = id_p1;
        data_n  = data_p1;
        gnt0_n  = 1'b0;
        gnt1_n  = 1'b0;
        case (state_p1)
            IDLE: begin
                if (!bus.flush && (bus.req0 || bus.req1)) begin
                    gnt0_n  = (sel_id == ID_ALU);
                    gnt1_n  = (sel_id == ID_BR);
                    vld_n   = 1'b1;
                    id_n    = sel_id;
                    data_n  = (sel_id == ID_BR) ? br_scale(ext_val) : ext_val;
                    state_n = RESP;
                end
            end
            RESP: begin
                // Flush wins over ack and deliberately leaves the pointer alone.
                if (bus.flush) begin
                    vld_n   = 1'b0;
                    state_n = IDLE;
                end else if (bus.out_ack) begin
                    vld_n   = 1'b0;
                    ptr_n   = ~id_p1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Registered stage: control and result captured together on the grant edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1 <= IDLE;
            ptr_p1   <= ID_ALU;
            vld_p1   <= 1'b0;
            id_p1    <= ID_ALU;
            data_p1  <= '0;
            gnt0_p1  <= 1'b0;
            gnt1_p1  <= 1'b0;
        end else begin
            state_p1 <= state_n;
            ptr_p1   <= ptr_n;
            vld_p1   <= vld_n;
            id_p1    <= id_n;
            data_p1  <= data_n;
            gnt0_p1  <= gnt0_n;
            gnt1_p1  <= gnt1_n;
        end
    end

    assign bus.gnt0      = gnt0_p1;
    assign bus.gnt1      = gnt1_p1;
    assign bus.out_valid = vld_p1;
    assign bus.out_id    = id_p1;
    assign bus.out_data  = data_p1;
endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Scoreboard bench for imm_ext_arbiter; honours IMM_ZERO_EXT_EN the same way as the design build.
module tb_imm_ext_arbiter;
    localparam int BR_SHIFT = 2;
`ifdef IMM_ZERO_EXT_EN
    localparam bit ZEXT_EN = 1'b1;
`else
    localparam bit ZEXT_EN = 1'b0;
`endif

    typedef struct {
        logic        id;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst;
    imm_ext_arbiter_if bus();

    imm_ext_arbiter #(.BR_SHIFT(BR_SHIFT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic ptr_m    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] model(input logic [15:0] imm, input bit z, input bit id);
        logic [31:0] v;
        v = {{16{imm[15]}}, imm};
        if (z && ZEXT_EN)
            v = {16'h0000, imm};
        if (id)
            v = v << BR_SHIFT;
        return v;
    endfunction

    // Drive a request, predict the winner, wait for its grant and compare the result.
    task automatic issue(input bit r0, input bit r1, input logic [15:0] i0, input logic [15:0] i1,
                         input bit z0, input bit z1);
        exp_t e;
        bit   got;
        bus.req0  = r0;
        bus.req1  = r1;
        bus.imm0  = i0;
        bus.imm1  = i1;
        bus.zext0 = z0;
        bus.zext1 = z1;
        e.id   = (r0 && r1) ? ptr_m : r1;
        e.data = model(e.id ? i1 : i0, e.id ? z1 : z0, e.id);
        sb.push_back(e);
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.gnt0 || bus.gnt1) begin
                got = 1'b1;
                break;
            end
        end
        check("grant_seen", {31'd0, got}, 32'd1);
        cur = sb.pop_front();
        if (!got) return;
        check("gnt_onehot", {30'd0, bus.gnt1, bus.gnt0}, cur.id ? 32'd2 : 32'd1);
        if (cur.id) bus.req1 = 1'b0;
        else        bus.req0 = 1'b0;
        check("out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("out_id",    {31'd0, bus.out_id},    {31'd0, cur.id});
        check("out_data",  bus.out_data,           cur.data);
    endtask

    // Hold the result a while, then end it with an ack or a flush+ack.
    task automatic complete(input bit use_flush);
        repeat (2) begin
            @(negedge clk);
            check("hold_gnt",   {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
            check("hold_valid", {31'd0, bus.out_valid},      32'd1);
            check("hold_data",  bus.out_data,                cur.data);
        end
        bus.flush   = use_flush;
        bus.out_ack = 1'b1;
        @(negedge clk);
        bus.flush   = 1'b0;
        bus.out_ack = 1'b0;
        check("done_valid", {31'd0, bus.out_valid}, 32'd0);
        if (!use_flush)
            ptr_m = ~cur.id;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, {31'd0, bus.out_valid},      32'd0);
        check({tag, "_id"},    {31'd0, bus.out_id},         32'd0);
        check({tag, "_data"},  bus.out_data,                32'd0);
        check({tag, "_gnt"},   {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        ptr_m = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.req0 = 0; bus.req1 = 0; bus.imm0 = '0; bus.imm1 = '0;
        bus.zext0 = 0; bus.zext1 = 0; bus.out_ack = 0; bus.flush = 0;
        do_reset();
        check_reset_state("rst");

        // Single requesters, sign/zero extension and branch scaling.
        issue(1, 0, 16'h8000, 16'h0000, 0, 0); complete(0);
        issue(0, 1, 16'h0000, 16'hFFFF, 0, 0); complete(0);
        issue(0, 1, 16'h0000, 16'h7FFF, 0, 0); complete(0);
        issue(1, 0, 16'h8000, 16'h0000, 1, 0); complete(0);

        // Flush in IDLE blocks a grant for that cycle.
        bus.flush = 1'b1;
        bus.req0  = 1'b1;
        bus.imm0  = 16'h1234;
        @(negedge clk);
        check("idle_flush_gnt",   {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
        check("idle_flush_valid", {31'd0, bus.out_valid},      32'd0);
        bus.flush = 1'b0;
        issue(1, 0, 16'h1234, 16'h0000, 0, 0); complete(0);

        // After reset, an ack in IDLE must not move the pointer; then strict alternation.
        do_reset();
        bus.out_ack = 1'b1;
        @(negedge clk);
        bus.out_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            issue(1, 1, 16'h00FF, 16'h8001, 0, 0);
            check("rr_order", {31'd0, cur.id}, k[0] ? 32'd1 : 32'd0);
            complete(0);
        end

        // Flush and ack together: pointer must not advance.
        issue(1, 1, 16'h0F0F, 16'hF0F0, 0, 1); complete(1);
        issue(1, 1, 16'h0F0F, 16'hF0F0, 0, 1);
        check("flush_same_req", {31'd0, cur.id}, 32'd0);
        complete(0);

        // Reset mid-RESP with both requests still asserted.
        issue(0, 1, 16'h0000, 16'h4000, 0, 0);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("midrst");
        rst   = 1'b0;
        ptr_m = 1'b0;
        issue(1, 1, 16'h0042, 16'h0024, 0, 0);
        check("post_rst_first", {31'd0, cur.id}, 32'd0);
        complete(0);

        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        check("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/imm_ext_arbiter.md
IMM_EXT_ARBITER -- requirements
Module: imm_ext_arbiter

Interface
REQ-001 The block SHALL use parameter BR_SHIFT, default 2, as the left-shift amount applied to requester-1 (branch offset) results.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset; reset is synchronous and active-high.
REQ-004 The block SHALL have ports req0 / req1, input, 1 bit each, request from ALU-immediate path / branch-offset path; each is held until its grant.
REQ-005 The block SHALL have ports imm0 / imm1, input, 16 bits each, raw immediates, sampled only on grant.
REQ-006 The block SHALL have ports zext0 / zext1, input, 1 bit each, zero-extend select, sampled with the immediate.
REQ-007 The block SHALL have ports gnt0 / gnt1, output, 1 bit each, registered one-cycle grant pulses.
REQ-008 The block SHALL have ports out_valid (1), out_id (1) and out_data (32), all outputs, giving the result, the serving requester and the extended value.
REQ-009 The block SHALL have port out_ack, input, 1 bit, consumer accepts result.
REQ-010 The block SHALL have port flush, input, 1 bit, pipeline flush that discards any held result.

Function
REQ-011 The FSM SHALL have two states: IDLE and RESP.
REQ-012 In IDLE with any req high, the block SHALL at the next edge:
- choose a requester by round-robin;
- capture its imm/zext;
- pulse its gnt for exactly one cycle;
- register out_data, set out_valid=1 and out_id;
- move to RESP.
REQ-013 When both req0 and req1 are high, the block SHALL grant the requester the priority pointer names; after reset the pointer SHALL name 0.
REQ-014 On every completed transaction (ack), the pointer SHALL move to the requester not just served.
REQ-015 The block SHALL compute extension as follows:
- sign mode: upper 16 bits = imm[15], lower 16 = imm;
- zero mode: upper 16 bits = 0.
REQ-016 For id 1, the block SHALL shift the 32-bit extended value left by BR_SHIFT, keep the low 32 bits, and fill with zeros.
REQ-017 In RESP, out_valid/out_id/out_data SHALL hold stable until out_ack; on the out_ack edge: out_valid=0, state IDLE.
REQ-018 The block SHALL have a minimum of 2 cycles per transaction, and SHALL issue no new grant while in RESP.
REQ-019 In RESP with flush=1, the block SHALL return to IDLE, set out_valid=0 and leave the pointer unchanged.
REQ-020 When flush and out_ack are both high in the same cycle, flush SHALL take precedence.
REQ-021 In IDLE, flush SHALL suppress granting that cycle.
REQ-022 out_ack SHALL be ignored in IDLE.
REQ-023 A req dropped before grant SHALL be legal and SHALL NOT be granted.

Reset
REQ-024 On rst=1 at an edge, the block SHALL set state=IDLE, pointer=0, out_valid=0, out_id=0, out_data=0, gnt0=gnt1=0.
REQ-025 rst SHALL override flush, out_ack and req, including mid-RESP: the result is discarded without ack.

Configuration
REQ-026 When IMM_ZERO_EXT_EN is defined, zext0/zext1 SHALL select zero mode per REQ-015.
REQ-027 When IMM_ZERO_EXT_EN is undefined, zext0/zext1 SHALL remain ports, be ignored, and all extension SHALL be sign mode.

Structure
REQ-028 Package imm_ext_pkg SHALL hold:
- IMM_W=16 and DATA_W=32;
- the FSM state enum (IDLE, RESP);
- requester id constants ID_ALU=0 and ID_BR=1.
REQ-029 The extension SHALL live in one combinational sub-module, sign_ext_unit (imm, zext -> 32-bit value).
REQ-030 The shift, arbitration and FSM SHALL stay in imm_ext_arbiter.

Verification
REQ-031 req0=1, imm0=0x8000, zext0=0 -> gnt0 pulse, next cycle out_valid=1, out_id=0, out_data=0xFFFF8000; held until out_ack.
REQ-032 req1=1, imm1=0xFFFF, zext1=0 -> out_id=1, out_data=0xFFFFFFFC; imm1=0x7FFF -> 0x0001FFFC.
REQ-033 req0=req1=1 continuously after reset, ack on each result -> grant order 0,1,0,1; never two results outstanding.
REQ-034 imm0=0x8000, zext0=1 -> 0x00008000 with IMM_ZERO_EXT_EN, 0xFFFF8000 without.
REQ-035 In RESP, flush=1 and out_ack=1 in the same cycle -> out_valid=0, pointer unchanged, next grant goes to the same requester as before.
REQ-036 rst asserted in RESP -> next cycle out_valid=0, out_data=0; then req0=req1=1 -> req0 granted first.
